// File: rtl/oric_ram_sched_if.sv
// rtl/oric_ram_sched_if.sv - Oric main RAM scheduler bus bundle: clear request, core port, tape stream, dpram port A
interface oric_ram_sched_if #(
  parameter int AW = 16
);
  logic          clr_req;
  logic          core_cs;
  logic          core_we;
  logic [AW-1:0] core_ad;
  logic [7:0]    core_d;
  logic [7:0]    core_q;
  logic          core_rvalid;
  logic          tape_req;
  logic [AW-1:0] tape_ad;
  logic [7:0]    tape_d;
  logic          tape_ack;
  logic          tape_starved;
  logic          busy;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_ad;
  logic [7:0]    mem_d;
  logic [7:0]    mem_q;

  modport slave (
    input  clr_req, core_cs, core_we, core_ad, core_d,
    input  tape_req, tape_ad, tape_d, mem_q,
    output core_q, core_rvalid, tape_ack, tape_starved, busy,
    output mem_cs, mem_we, mem_ad, mem_d
  );

  modport master (
    output clr_req, core_cs, core_we, core_ad, core_d,
    output tape_req, tape_ad, tape_d, mem_q,
    input  core_q, core_rvalid, tape_ack, tape_starved, busy,
    input  mem_cs, mem_we, mem_ad, mem_d
  );
endinterface

// File: rtl/oric_ram_sched.sv
// rtl/oric_ram_sched.sv - single-owner Oric RAM port scheduler: clear sweep, core priority, slotted tape writes
module oric_ram_sched #(
  parameter int       AW         = 16,
  parameter bit [7:0] FILL_VALUE = 8'h01,
  parameter int       STARVE_MAX = 1024
) (
  input  logic            clk_sys,
  input  logic            RESET,
  oric_ram_sched_if.slave bus
);
  localparam int            SW         = $clog2(STARVE_MAX + 1);
  localparam logic [AW-1:0] LAST_ADDR  = {AW{1'b1}};
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [AW-1:0] r_clr_addr;
  logic          r_busy;
  logic          r_mem_cs;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_ad;
  logic [7:0]    r_mem_d;
  logic          r_tape_ack;
  logic          r_rd_pend;
  logic          r_core_rvalid;
  logic [SW-1:0] r_starve_cnt;
  logic          r_tape_starved;

  logic          w_in_run;
  logic          w_tape_grant;
  logic [AW-1:0] w_clr_ad;
  logic [AW-1:0] w_clr_addr_nxt;
  logic          w_mem_cs_nxt;
  logic          w_mem_we_nxt;
  logic [AW-1:0] w_mem_ad_nxt;
  logic [7:0]    w_mem_d_nxt;
  logic          w_rd_pend_nxt;
  logic [SW-1:0] w_starve_nxt;
  logic          w_starved_nxt;

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clr_req) begin
      w_state_nxt = ST_CLEAR;
    end else if (r_state == ST_CLEAR && r_clr_addr == LAST_ADDR) begin
      w_state_nxt = ST_RUN;
    end
  end

  // A clr_req edge behaves like a CLEAR edge at address 0, whatever the current state.
  always_comb begin
    w_in_run       = (r_state == ST_RUN) && !bus.clr_req;
    w_tape_grant   = w_in_run && !bus.core_cs && bus.tape_req && !r_tape_ack;
    w_clr_ad       = bus.clr_req ? '0 : r_clr_addr;
    w_clr_addr_nxt = r_clr_addr;
    w_mem_cs_nxt   = 1'b0;
    w_mem_we_nxt   = 1'b0;
    w_mem_ad_nxt   = r_mem_ad;
    w_mem_d_nxt    = r_mem_d;
    w_rd_pend_nxt  = 1'b0;
    w_starve_nxt   = r_starve_cnt;
    w_starved_nxt  = r_tape_starved;

    if (!w_in_run) begin
      w_mem_cs_nxt   = 1'b1;
      w_mem_we_nxt   = 1'b1;
      w_mem_ad_nxt   = w_clr_ad;
      w_mem_d_nxt    = FILL_VALUE;
      w_clr_addr_nxt = w_clr_ad + AW'(1);
      w_starve_nxt   = '0;
    end else if (bus.core_cs) begin
      w_mem_cs_nxt  = 1'b1;
      w_mem_we_nxt  = bus.core_we;
      w_mem_ad_nxt  = bus.core_ad;
      w_mem_d_nxt   = bus.core_d;
      w_rd_pend_nxt = !bus.core_we;
    end else if (w_tape_grant) begin
      w_mem_cs_nxt = 1'b1;
      w_mem_we_nxt = 1'b1;
      w_mem_ad_nxt = bus.tape_ad;
      w_mem_d_nxt  = bus.tape_d;
    end

    if (w_tape_grant) begin
      w_starve_nxt  = '0;
      w_starved_nxt = 1'b0;
    end else if (w_in_run && bus.tape_req) begin
      if (r_starve_cnt != STARVE_LIM) begin
        w_starve_nxt = r_starve_cnt + SW'(1);
      end
      if (w_starve_nxt == STARVE_LIM) begin
        w_starved_nxt = 1'b1;
      end
    end
  end

  // core_rvalid trails the read command by one edge, matching the RAM's read latency.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_clr_addr     <= '0;
      r_busy         <= 1'b1;
      r_mem_cs       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_ad       <= '0;
      r_mem_d        <= '0;
      r_tape_ack     <= 1'b0;
      r_rd_pend      <= 1'b0;
      r_core_rvalid  <= 1'b0;
      r_starve_cnt   <= '0;
      r_tape_starved <= 1'b0;
    end else begin
      r_clr_addr     <= w_clr_addr_nxt;
      r_busy         <= (w_state_nxt == ST_CLEAR);
      r_mem_cs       <= w_mem_cs_nxt;
      r_mem_we       <= w_mem_we_nxt;
      r_mem_ad       <= w_mem_ad_nxt;
      r_mem_d        <= w_mem_d_nxt;
      r_tape_ack     <= w_tape_grant;
      r_rd_pend      <= w_rd_pend_nxt;
      r_core_rvalid  <= r_rd_pend;
      r_starve_cnt   <= w_starve_nxt;
      r_tape_starved <= w_starved_nxt;
    end
  end

  assign bus.core_q       = bus.mem_q;
  assign bus.core_rvalid  = r_core_rvalid;
  assign bus.tape_ack     = r_tape_ack;
  assign bus.tape_starved = r_tape_starved;
  assign bus.busy         = r_busy;
  assign bus.mem_cs       = r_mem_cs;
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_ad       = r_mem_ad;
  assign bus.mem_d        = r_mem_d;
endmodule

// File: tb/tb_oric_ram_sched.sv
// tb/tb_oric_ram_sched.sv - scoreboard bench for oric_ram_sched against a behavioural port-sharing model
`timescale 1ns/1ps
module tb_oric_ram_sched;
  localparam int         AW    = 8;
  localparam int         DEPTH = 1 << AW;
  localparam int         SMAX  = 16;
  localparam logic [7:0] FILL  = 8'h01;

  logic clk_sys = 1'b0;
  logic RESET   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  oric_ram_sched_if #(.AW(AW)) bus ();

  oric_ram_sched #(.AW(AW), .FILL_VALUE(FILL), .STARVE_MAX(SMAX)) dut (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .bus     (bus.slave)
  );

  // dpram port A stand-in: one-cycle read latency
  logic [7:0] ram [DEPTH];
  initial bus.mem_q = 8'h00;
  always @(posedge clk_sys) begin
    if (bus.mem_cs) begin
      if (bus.mem_we) ram[bus.mem_ad] <= bus.mem_d;
      else            bus.mem_q <= ram[bus.mem_ad];
    end
  end

  typedef struct {
    bit            cs;
    bit            we;
    logic [AW-1:0] ad;
    logic [7:0]    d;
    bit            chk_ad;
    bit            ack;
    bit            rv;
    logic [7:0]    q;
    bit            busy;
    bit            starved;
    string         tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk_sys) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, ".mem_cs"}, bus.mem_cs, e.cs);
      if (e.cs) begin
        chk({e.tag, ".mem_we"}, bus.mem_we, e.we);
        chk({e.tag, ".mem_ad"}, bus.mem_ad, e.ad);
        chk({e.tag, ".mem_d"},  bus.mem_d,  e.d);
      end
      if (e.chk_ad) begin
        chk({e.tag, ".rst_mem_we"}, bus.mem_we, 0);
        chk({e.tag, ".rst_mem_ad"}, bus.mem_ad, 0);
        chk({e.tag, ".rst_mem_d"},  bus.mem_d,  0);
      end
      chk({e.tag, ".tape_ack"},    bus.tape_ack,    e.ack);
      chk({e.tag, ".core_rvalid"}, bus.core_rvalid, e.rv);
      if (e.rv) chk({e.tag, ".core_q"}, bus.core_q, e.q);
      chk({e.tag, ".busy"},         bus.busy,         e.busy);
      chk({e.tag, ".tape_starved"}, bus.tape_starved, e.starved);
    end
  end

  // reference model: who owns the port on each edge, and what RAM should hold
  bit            m_clear = 1'b1;
  int            m_pos = 0;
  bit            m_last_ack = 1'b0;
  bit            m_rd_pend = 1'b0;
  logic [7:0]    m_rd_data = 8'h00;
  int            m_starve = 0;
  bit            m_starved = 1'b0;
  logic [7:0]    ref_mem [DEPTH];
  bit            t_req = 1'b0;
  logic [AW-1:0] t_ad = '0;
  logic [7:0]    t_d = 8'h00;
  bit            granted = 1'b0;
  string         cur_tag = "init";

  task automatic step(input bit rst, input bit clr, input bit ccs, input bit cwe,
                      input logic [AW-1:0] cad, input logic [7:0] cd);
    exp_t e;
    @(negedge clk_sys);
    RESET        = rst;
    bus.clr_req  = clr;
    bus.core_cs  = ccs;
    bus.core_we  = cwe;
    bus.core_ad  = cad;
    bus.core_d   = cd;
    bus.tape_req = t_req;
    bus.tape_ad  = t_ad;
    bus.tape_d   = t_d;

    e.cs = 0; e.we = 0; e.ad = '0; e.d = 8'h00; e.chk_ad = 0; e.ack = 0;
    e.tag = cur_tag;
    e.rv  = rst ? 1'b0 : m_rd_pend;
    e.q   = m_rd_data;
    m_rd_pend = 0;
    granted   = 0;

    if (rst) begin
      m_clear = 1; m_pos = 0; m_starve = 0; m_starved = 0;
      e.chk_ad = 1;
    end else if (clr || m_clear) begin
      if (clr) m_pos = 0;
      e.cs = 1; e.we = 1; e.ad = AW'(m_pos); e.d = FILL;
      ref_mem[m_pos] = FILL;
      m_clear  = (m_pos != DEPTH - 1);
      m_pos    = (m_pos + 1) % DEPTH;
      m_starve = 0;
    end else begin
      if (ccs) begin
        e.cs = 1; e.we = cwe; e.ad = cad; e.d = cd;
        if (cwe) ref_mem[cad] = cd;
        else begin
          m_rd_pend = 1;
          m_rd_data = ref_mem[cad];
        end
      end else if (t_req && !m_last_ack) begin
        granted = 1;
        e.cs = 1; e.we = 1; e.ad = t_ad; e.d = t_d;
        ref_mem[t_ad] = t_d;
      end
      if (granted) begin
        m_starve = 0; m_starved = 0;
      end else if (t_req) begin
        if (m_starve < SMAX) m_starve++;
        if (m_starve == SMAX) m_starved = 1;
      end
    end
    m_last_ack = granted;
    e.ack      = granted;
    e.busy     = m_clear;
    e.starved  = m_starved;
    exp_q.push_back(e);
  endtask

  task automatic idle_until_grant(input int budget);
    int k;
    k = 0;
    while (k < budget) begin
      step(0, 0, 0, 0, '0, 8'h00);
      k++;
      if (granted) begin
        t_req = 0;
        k = budget + 1;
      end
    end
    if (k == budget) chk({cur_tag, ".grant_timeout"}, 1, 0);
  endtask

  initial begin
    int nbad;
    int got;
    bus.clr_req = 0; bus.core_cs = 0; bus.core_we = 0; bus.core_ad = '0; bus.core_d = 8'h00;
    bus.tape_req = 0; bus.tape_ad = '0; bus.tape_d = 8'h00;

    cur_tag = "reset";
    repeat (3) step(1, 0, 0, 0, '0, 8'h00);

    cur_tag = "sweep";
    t_req = 1; t_ad = 8'h80; t_d = 8'hA5;
    for (int i = 0; i < DEPTH; i++)
      step(0, 0, 1'($urandom), 1'($urandom), AW'($urandom), 8'($urandom));
    cur_tag = "post_sweep_tape";
    idle_until_grant(3);

    cur_tag = "core_rw";
    step(0, 0, 1, 1, 8'h12, 8'h34);
    step(0, 0, 1, 0, 8'h12, 8'h00);
    step(0, 0, 0, 0, '0, 8'h00);
    step(0, 0, 0, 0, '0, 8'h00);

    cur_tag = "tape4";
    t_req = 1; t_ad = 8'h40; t_d = 8'($urandom);
    got = 0;
    for (int i = 0; i < 20 && got < 4; i++) begin
      step(0, 0, 0, 0, '0, 8'h00);
      if (granted) begin
        got++;
        if (got == 4) t_req = 0;
        else begin
          t_ad = t_ad + 1'b1;
          t_d  = 8'($urandom);
        end
      end
    end
    chk("tape4.ack_count", got, 4);
    step(0, 0, 0, 0, '0, 8'h00);

    cur_tag = "contend";
    t_req = 1; t_ad = 8'h50; t_d = 8'hC3;
    for (int i = 0; i < 10; i++)
      step(0, 0, 1, 1'($urandom), AW'($urandom), 8'($urandom));
    idle_until_grant(2);

    cur_tag = "starve";
    t_req = 1; t_ad = 8'h60; t_d = 8'h96;
    for (int i = 0; i < 20; i++)
      step(0, 0, 1, 0, AW'($urandom), 8'h00);
    idle_until_grant(2);

    cur_tag = "clr_mid_run";
    t_req = 1; t_ad = 8'h70; t_d = 8'h3C;
    step(0, 0, 1, 0, 8'h12, 8'h00);
    step(0, 1, 1, 1, 8'h13, 8'hEE);
    for (int i = 0; i < DEPTH - 1; i++)
      step(0, 0, 1'($urandom), 1'($urandom), AW'($urandom), 8'($urandom));
    idle_until_grant(2);

    cur_tag = "random";
    for (int i = 0; i < 500; i++) begin
      step(0, 0, ($urandom_range(0, 9) < 6), 1'($urandom), AW'($urandom), 8'($urandom));
      if (granted) begin
        if ($urandom_range(0, 1) == 0) t_req = 0;
        else begin
          t_ad = AW'($urandom);
          t_d  = 8'($urandom);
        end
      end else if (!t_req && $urandom_range(0, 3) == 0) begin
        t_req = 1;
        t_ad  = AW'($urandom);
        t_d   = 8'($urandom);
      end
    end
    t_req = 0;

    cur_tag = "drain";
    repeat (3) step(0, 0, 0, 0, '0, 8'h00);
    repeat (3) @(posedge clk_sys);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);

    nbad = 0;
    for (int a = 0; a < DEPTH; a++)
      if (ram[a] !== ref_mem[a]) nbad++;
    chk("ram_contents_bad_locations", nbad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
